// File: rtl/alu_issue_unit.sv
// ALU issue unit: picks one ready reservation-station slot per cycle in
// round-robin order and runs it through a two-stage pipe. E1 holds the
// captured operands and E2 holds the result. Each result is offered on the
// CDB with a req/gnt handshake, and the originating slot is notified when
// the CDB accepts it.

package alu_issue_pkg;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_XOR, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU
    } cmp_op_e;

    // Reservation-station entry as seen by the issue unit.
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        alu_op_e     alu_opcode;
        cmp_op_e     cmp_opcode;
        logic        valid;
    } rs_t;

    // Per-slot completion notice sent back to the reservation station.
    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  tag;
    } sal_t;

endpackage

module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int size   = 8,
    parameter int SLOT_W = 3   // must equal $clog2(size)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  rs_t               data_i          [size],
    input  logic [size-1:0]   acu_operation_i,
    input  logic [size-1:0]   ready_i,
    output logic              cdb_req_o,
    input  logic              cdb_gnt_i,
    output logic [3:0]        cdb_tag_o,
    output logic [31:0]       cdb_data_o,
    output sal_t              broadcast_o     [size],
    output logic [size-1:0]   inflight_o
);

    typedef struct packed {
        logic              v;
        logic [SLOT_W-1:0] slot;
        logic [3:0]        tag;
        logic [31:0]       r1;
        logic [31:0]       r2;
        alu_op_e           alu_op;
        cmp_op_e           cmp_op;
        logic              acu;
    } e1_t;

    typedef struct packed {
        logic              v;
        logic [SLOT_W-1:0] slot;
        logic [3:0]        tag;
        logic [31:0]       data;
    } e2_t;

    e1_t               e1_q, e1_d;
    e2_t               e2_q, e2_d;
    logic [size-1:0]   inflight_q, inflight_d;
    logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [size-1:0]   cand;
    logic              any_cand;
    logic [SLOT_W-1:0] grant;
    logic              stall;
    logic              issue;
    logic              complete;
    logic [31:0]       e1_result;

    // A slot is eligible when the RS marks it ready and valid and it is not already in the pipe.
    always_comb begin
        for (int i = 0; i < size; i++) begin
            cand[i] = ready_i[i] & data_i[i].valid & ~inflight_q[i];
        end
    end

    // Round-robin pick: the first candidate at or after rr_ptr, wrapping modulo size.
    always_comb begin
        logic [SLOT_W-1:0] idx;
        // NOTE: every variable driven in a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        any_cand = 1'b0;
        grant    = '0;
        idx      = '0;
        for (int i = 0; i < size; i++) begin
            idx = rr_ptr_q + SLOT_W'(i);
            if (!any_cand && cand[idx]) begin
                any_cand = 1'b1;
                grant    = idx;
            end
        end
    end

    assign stall    = e2_q.v & ~cdb_gnt_i;
    assign issue    = any_cand & ~(e1_q.v & stall);
    assign complete = e2_q.v & cdb_gnt_i & ~flush & ~rst;

    // Execute the E1 op: a 32-bit ALU op, or a compare producing a 0/1 result.
    always_comb begin
        logic [4:0]  shamt;
        logic [31:0] alu_res;
        logic        cmp_res;
        shamt   = e1_q.r2[4:0];
        alu_res = '0;
        cmp_res = 1'b0;
        case (e1_q.alu_op)
            ALU_ADD: alu_res = e1_q.r1 + e1_q.r2;
            ALU_SUB: alu_res = e1_q.r1 - e1_q.r2;
            ALU_SLL: alu_res = e1_q.r1 << shamt;
            ALU_SRL: alu_res = e1_q.r1 >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(e1_q.r1) >>> shamt);
            ALU_XOR: alu_res = e1_q.r1 ^ e1_q.r2;
            ALU_OR:  alu_res = e1_q.r1 | e1_q.r2;
            ALU_AND: alu_res = e1_q.r1 & e1_q.r2;
            default: alu_res = '0;
        endcase
        case (e1_q.cmp_op)
            CMP_BEQ:  cmp_res = (e1_q.r1 == e1_q.r2);
            CMP_BNE:  cmp_res = (e1_q.r1 != e1_q.r2);
            CMP_BLT:  cmp_res = ($signed(e1_q.r1) <  $signed(e1_q.r2));
            CMP_BGE:  cmp_res = ($signed(e1_q.r1) >= $signed(e1_q.r2));
            CMP_BLTU: cmp_res = (e1_q.r1 <  e1_q.r2);
            CMP_BGEU: cmp_res = (e1_q.r1 >= e1_q.r2);
            default:  cmp_res = 1'b0;
        endcase
        e1_result = e1_q.acu ? {31'b0, cmp_res} : alu_res;
    end

    // Next-state for the pipe, the in-flight mask and the round-robin pointer.
    always_comb begin
        e1_d       = e1_q;
        e2_d       = e2_q;
        inflight_d = inflight_q;
        rr_ptr_d   = rr_ptr_q;

        // E2 takes the E1 op whenever it is not blocked on the CDB; otherwise it holds.
        if (!stall) begin
            if (e1_q.v) begin
                e2_d.v    = 1'b1;
                e2_d.slot = e1_q.slot;
                e2_d.tag  = e1_q.tag;
                e2_d.data = e1_result;
            end else begin
                e2_d.v = 1'b0;
            end
        end

        // E1 captures a new op (operands frozen here), empties after advancing, or holds.
        if (issue) begin
            e1_d.v      = 1'b1;
            e1_d.slot   = grant;
            e1_d.tag    = data_i[grant].tag;
            e1_d.r1     = data_i[grant].r1;
            e1_d.r2     = data_i[grant].r2;
            e1_d.alu_op = data_i[grant].alu_opcode;
            e1_d.cmp_op = data_i[grant].cmp_opcode;
            e1_d.acu    = acu_operation_i[grant];
            rr_ptr_d    = grant + SLOT_W'(1);
        end else if (!stall) begin
            e1_d.v = 1'b0;
        end

        // Issue and completion always refer to different slots, so both updates apply.
        if (complete) inflight_d[e2_q.slot] = 1'b0;
        if (issue)    inflight_d[grant]     = 1'b1;
    end

    // State registers; reset and flush both empty the pipe and zero the CDB outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst || flush) begin
            e1_q       <= '0;
            e2_q       <= '0;
            inflight_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign cdb_req_o  = e2_q.v;
    assign cdb_tag_o  = e2_q.tag;
    assign cdb_data_o = e2_q.data;
    assign inflight_o = inflight_q;

    // One-cycle completion notice to the slot whose result the CDB accepts now.
    always_comb begin
        for (int i = 0; i < size; i++) begin
            broadcast_o[i] = '0;
        end
        if (complete) begin
            broadcast_o[e2_q.slot].rdy  = 1'b1;
            broadcast_o[e2_q.slot].data = e2_q.data;
            broadcast_o[e2_q.slot].tag  = e2_q.tag;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed scenarios with hand-computed values,
// then a long randomized run. A queue-based model of the ops in flight
// supplies the expected outputs, and the bench compares them every cycle.
module tb_alu_issue_unit;
    import alu_issue_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    rs_t         data_i [N];
    logic [N-1:0] acu_i;
    logic [N-1:0] ready_i;
    logic        cdb_req_o;
    logic        cdb_gnt_i;
    logic [3:0]  cdb_tag_o;
    logic [31:0] cdb_data_o;
    sal_t        broadcast_o [N];
    logic [N-1:0] inflight_o;

    always #5 clk = ~clk;

    alu_issue_unit #(.size(N), .SLOT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .data_i          (data_i),
        .acu_operation_i (acu_i),
        .ready_i         (ready_i),
        .cdb_req_o       (cdb_req_o),
        .cdb_gnt_i       (cdb_gnt_i),
        .cdb_tag_o       (cdb_tag_o),
        .cdb_data_o      (cdb_data_o),
        .broadcast_o     (broadcast_o),
        .inflight_o      (inflight_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ops in flight, oldest first. stage 1 = captured, stage 2 = offered on the CDB.
    typedef struct {
        int          slot;
        logic [3:0]  tag;
        logic [31:0] res;
        int          stage;
    } op_t;

    op_t         pipe[$];
    int          rr = 0;
    logic        m_req, m_done;
    logic [N-1:0] m_infl;
    logic [N-1:0] clr_pend = '0;
    bit          auto_clear = 1'b1;

    function automatic logic [31:0] ref_result(input rs_t e, input logic acu);
        int unsigned sh;
        sh = e.r2 % 32;
        if (acu) begin
            case (e.cmp_opcode)
                CMP_BEQ:  return {31'b0, e.r1 == e.r2};
                CMP_BNE:  return {31'b0, e.r1 != e.r2};
                CMP_BLT:  return {31'b0, $signed(e.r1) <  $signed(e.r2)};
                CMP_BGE:  return {31'b0, $signed(e.r1) >= $signed(e.r2)};
                CMP_BLTU: return {31'b0, e.r1 <  e.r2};
                CMP_BGEU: return {31'b0, e.r1 >= e.r2};
                default:  return 32'd0;
            endcase
        end
        case (e.alu_opcode)
            ALU_ADD: return e.r1 + e.r2;
            ALU_SUB: return e.r1 - e.r2;
            ALU_SLL: return e.r1 << sh;
            ALU_SRL: return e.r1 >> sh;
            ALU_SRA: return 32'($signed(e.r1) >>> sh);
            ALU_XOR: return e.r1 ^ e.r2;
            ALU_OR:  return e.r1 | e.r2;
            default: return e.r1 & e.r2;
        endcase
    endfunction

    // Compare DUT outputs with what the model says for the current cycle.
    task automatic compare();
        int hs;
        m_infl = '0;
        foreach (pipe[j]) m_infl[pipe[j].slot] = 1'b1;
        m_req  = 1'b0;
        hs     = -1;
        if (pipe.size() > 0) begin
            if (pipe[0].stage == 2) begin
                m_req = 1'b1;
                hs    = pipe[0].slot;
            end
        end
        m_done = m_req && cdb_gnt_i && !flush && !rst;
        check("cdb_req", 64'(cdb_req_o), 64'(m_req));
        if (m_req) begin
            check("cdb_tag", 64'(cdb_tag_o), 64'(pipe[0].tag));
            check("cdb_data", 64'(cdb_data_o), 64'(pipe[0].res));
        end
        check("inflight", 64'(inflight_o), 64'(m_infl));
        for (int i = 0; i < N; i++) begin
            check($sformatf("bc_rdy[%0d]", i), 64'(broadcast_o[i].rdy), 64'(m_done && hs == i));
            if (m_done && hs == i) begin
                check($sformatf("bc_data[%0d]", i), 64'(broadcast_o[i].data), 64'(pipe[0].res));
                check($sformatf("bc_tag[%0d]", i), 64'(broadcast_o[i].tag), 64'(pipe[0].tag));
            end
        end
    endtask

    // Move the model one clock forward using this cycle's inputs.
    task automatic advance();
        bit blocked, e1_busy;
        int k, s;
        clr_pend = '0;
        if (rst || flush) begin
            pipe.delete();
            rr = 0;
            return;
        end
        blocked = m_req && !cdb_gnt_i;
        e1_busy = (pipe.size() > 0) && (pipe[pipe.size()-1].stage == 1);
        k = -1;
        for (int off = 0; off < N; off++) begin
            s = (rr + off) % N;
            if (k < 0 && ready_i[s] && data_i[s].valid && !m_infl[s]) k = s;
        end
        if (m_done) begin
            clr_pend[pipe[0].slot] = 1'b1;
            void'(pipe.pop_front());
        end
        if (!blocked) begin
            foreach (pipe[j]) pipe[j].stage = 2;
        end
        if (k >= 0 && !(e1_busy && blocked)) begin
            op_t o;
            o.slot  = k;
            o.tag   = data_i[k].tag;
            o.res   = ref_result(data_i[k], acu_i[k]);
            o.stage = 1;
            pipe.push_back(o);
            rr = (k + 1) % N;
        end
    endtask

    task automatic cyc_a();
        @(negedge clk);
        compare();
    endtask

    task automatic cyc_b();
        advance();
        @(posedge clk);
        #1;
        if (auto_clear) ready_i = ready_i & ~clr_pend;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) data_i[i] = '0;
        acu_i   = '0;
        ready_i = '0;
    endtask

    task automatic set_slot(input int i, input logic [3:0] tag, input logic [31:0] r1,
                            input logic [31:0] r2, input alu_op_e aop, input cmp_op_e cop,
                            input logic acu);
        data_i[i].tag        = tag;
        data_i[i].r1         = r1;
        data_i[i].r2         = r2;
        data_i[i].alu_opcode = aop;
        data_i[i].cmp_opcode = cop;
        data_i[i].valid      = 1'b1;
        acu_i[i]             = acu;
    endtask

    task automatic do_reset();
        clear_slots();
        flush     = 1'b0;
        cdb_gnt_i = 1'b1;
        rst       = 1'b1;
        cyc_a();
        cyc_b();
        rst = 1'b0;
    endtask

    initial begin
        clear_slots();
        rst       = 1'b1;
        flush     = 1'b0;
        cdb_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, literal values.
        cyc_a();
        check("rst_req", 64'(cdb_req_o), 64'd0);
        check("rst_tag", 64'(cdb_tag_o), 64'd0);
        check("rst_data", 64'(cdb_data_o), 64'd0);
        check("rst_infl", 64'(inflight_o), 64'd0);
        for (int i = 0; i < N; i++) check($sformatf("rst_bc[%0d]", i), 64'(broadcast_o[i]), 64'd0);
        cyc_b();

        // 1: single add in slot 2.
        do_reset();
        set_slot(2, 4'd3, 32'd5, 32'd7, ALU_ADD, CMP_BEQ, 1'b0);
        ready_i   = 8'b0000_0100;
        cdb_gnt_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc_a();
            if (c == 1) check("t1_req_c1", 64'(cdb_req_o), 64'd0);
            if (c == 2) begin
                check("t1_req", 64'(cdb_req_o), 64'd1);
                check("t1_tag", 64'(cdb_tag_o), 64'd3);
                check("t1_data", 64'(cdb_data_o), 64'd12);
                check("t1_bc2", 64'(broadcast_o[2].rdy), 64'd1);
            end
            if (c == 3) begin
                check("t1_bc2_off", 64'(broadcast_o[2].rdy), 64'd0);
                check("t1_infl", 64'(inflight_o), 64'd0);
            end
            cyc_b();
        end

        // 2: back-to-back, slots 0..3.
        do_reset();
        for (int i = 0; i < 4; i++)
            set_slot(i, 4'(8 + i), 32'(i * 100), 32'(i), ALU_ADD, CMP_BEQ, 1'b0);
        ready_i = 8'h0F;
        for (int c = 0; c < 7; c++) begin
            cyc_a();
            if (c >= 2 && c <= 5) begin
                check($sformatf("t2_tag_c%0d", c), 64'(cdb_tag_o), 64'(8 + c - 2));
                check($sformatf("t2_data_c%0d", c), 64'(cdb_data_o), 64'((c - 2) * 101));
                check($sformatf("t2_bc_c%0d", c), 64'(broadcast_o[c - 2].rdy), 64'd1);
            end
            cyc_b();
        end

        // 3: backpressure, gnt low for cycles 0..5.
        do_reset();
        for (int i = 0; i < 3; i++)
            set_slot(i, 4'(i + 1), 32'(i + 1), 32'd1, ALU_ADD, CMP_BEQ, 1'b0);
        ready_i = 8'h07;
        for (int c = 0; c < 10; c++) begin
            cdb_gnt_i = (c >= 6);
            cyc_a();
            if (c >= 2 && c <= 5) begin
                check($sformatf("t3_req_c%0d", c), 64'(cdb_req_o), 64'd1);
                check($sformatf("t3_tag_c%0d", c), 64'(cdb_tag_o), 64'd1);
                check($sformatf("t3_data_c%0d", c), 64'(cdb_data_o), 64'd2);
                check($sformatf("t3_infl_c%0d", c), 64'(inflight_o), 64'h03);
            end
            if (c >= 6 && c <= 8) begin
                check($sformatf("t3_bc_c%0d", c), 64'(broadcast_o[c - 6].rdy), 64'd1);
                check($sformatf("t3_tag_c%0d", c), 64'(cdb_tag_o), 64'(c - 5));
            end
            if (c == 9) check("t3_req_end", 64'(cdb_req_o), 64'd0);
            cyc_b();
        end

        // 4: compare and shift results.
        do_reset();
        set_slot(0, 4'd4, 32'd1, 32'hFFFF_FFFF, ALU_ADD, CMP_BLTU, 1'b1);
        set_slot(1, 4'd5, 32'h8000_0000, 32'd4, ALU_SRA, CMP_BEQ, 1'b0);
        set_slot(2, 4'd6, 32'hFFFF_FFFF, 32'd0, ALU_ADD, CMP_BLT, 1'b1);
        ready_i = 8'h07;
        for (int c = 0; c < 6; c++) begin
            cyc_a();
            if (c == 2) check("t4_sltu", 64'(cdb_data_o), 64'd1);
            if (c == 3) check("t4_sra", 64'(cdb_data_o), 64'hF800_0000);
            if (c == 4) check("t4_slt", 64'(cdb_data_o), 64'd1);
            cyc_b();
        end

        // 5: round-robin with all slots continuously ready.
        do_reset();
        auto_clear = 1'b0;
        for (int i = 0; i < N; i++)
            set_slot(i, 4'(i + 3), 32'(i), 32'd0, ALU_ADD, CMP_BEQ, 1'b0);
        ready_i = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            cyc_a();
            if (c >= 2) begin
                check($sformatf("t5_tag_c%0d", c), 64'(cdb_tag_o), 64'(((c - 2) % N) + 3));
                check($sformatf("t5_bc_c%0d", c), 64'(broadcast_o[(c - 2) % N].rdy), 64'd1);
            end
            cyc_b();
        end
        ready_i = '0;
        auto_clear = 1'b1;
        repeat (3) begin
            cyc_a();
            cyc_b();
        end

        // 6: flush with E1 and E2 both valid and gnt high.
        do_reset();
        set_slot(0, 4'd1, 32'd1, 32'd1, ALU_ADD, CMP_BEQ, 1'b0);
        set_slot(1, 4'd2, 32'd2, 32'd2, ALU_ADD, CMP_BEQ, 1'b0);
        ready_i = 8'h03;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                flush   = 1'b1;
                ready_i = '0;
            end
            if (c == 3) begin
                flush = 1'b0;
                set_slot(5, 4'd9, 32'd2, 32'd3, ALU_ADD, CMP_BEQ, 1'b0);
                ready_i = 8'h20;
            end
            cyc_a();
            if (c == 2) begin
                check("t6_req_pre", 64'(cdb_req_o), 64'd1);
                check("t6_infl_pre", 64'(inflight_o), 64'h03);
                for (int i = 0; i < N; i++)
                    check($sformatf("t6_bc[%0d]", i), 64'(broadcast_o[i].rdy), 64'd0);
            end
            if (c == 3) begin
                check("t6_req_post", 64'(cdb_req_o), 64'd0);
                check("t6_infl_post", 64'(inflight_o), 64'd0);
            end
            if (c == 5) begin
                check("t6_new_req", 64'(cdb_req_o), 64'd1);
                check("t6_new_tag", 64'(cdb_tag_o), 64'd9);
                check("t6_new_data", 64'(cdb_data_o), 64'd5);
            end
            cyc_b();
        end

        // Randomized traffic: operands change every cycle, including for slots in flight.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                data_i[i].tag        = 4'($urandom);
                data_i[i].r1         = $urandom;
                data_i[i].r2         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                data_i[i].alu_opcode = alu_op_e'($urandom_range(0, 7));
                data_i[i].cmp_opcode = cmp_op_e'($urandom_range(0, 5));
                data_i[i].valid      = ($urandom_range(0, 7) != 0);
                acu_i[i]             = 1'($urandom);
                ready_i[i]           = 1'($urandom);
            end
            cdb_gnt_i = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc_a();
            cyc_b();
        end
        rst   = 1'b0;
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
